// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared types and constants for the Bitty fetch sequencer
package bitty_pkg;

    localparam int INSTR_W     = 16;
    localparam int ADDR_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_EXEC     = 3'd4,
        ST_ADVANCE  = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// rtl/bitty_watchdog.sv - per-instruction cycle watchdog with clear/enable
module bitty_watchdog
    import bitty_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(TIMEOUT - 1))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Expires on the cycle whose increment would bring the count to TIMEOUT-1.
    assign expire_o = en_i && (count_q == CW'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bitty_fetch_sequencer.sv
// rtl/bitty_fetch_sequencer.sv - steps the Bitty core through a stored program
module bitty_fetch_sequencer
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W-1:0]  last_addr,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    input  logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               finished,
    output logic               timeout_err,
    output logic [15:0]        instr_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [15:0]         count_q, count_d;
    logic                terr_q, terr_d;
    logic                wd_clear;
    logic                wd_en;
    logic                wd_expire;

    bitty_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        instr_d  = instr_q;
        count_d  = count_q;
        terr_d   = terr_q;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    pc_d    = '0;
                    last_d  = last_addr;
                    count_d = '0;
                    terr_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                instr_d = mem_rdata;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                wd_en = 1'b1;
                // done takes priority over a same-cycle watchdog expiry
                if (done) begin
                    count_d = sat_inc16(count_q);
                    state_d = ST_ADVANCE;
                end else if (wd_expire) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ADVANCE: begin
                if (pc_q == last_q) begin
                    state_d = ST_FINISH;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort leaves pc/instruction/count as they were for post-mortem inspection.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            pc_d    = pc_q;
            instr_d = instr_q;
            count_d = count_q;
            terr_d  = terr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            instr_q <= '0;
            count_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            count_q <= count_d;
            terr_q  <= terr_d;
        end
    end

    assign mem_rd      = (state_q == ST_FETCH)  && !stop;
    assign run         = (state_q == ST_ISSUE)  && !stop;
    assign finished    = (state_q == ST_FINISH) && !stop;
    assign busy        = (state_q != ST_IDLE);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign timeout_err = terr_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// tb/tb_bitty_fetch_sequencer.sv - scoreboard bench for bitty_fetch_sequencer
module tb_bitty_fetch_sequencer;

    localparam int AW = 4;
    localparam int TO = 8;
    localparam int N  = 1 << AW;
    localparam int EV_RD  = 0;
    localparam int EV_RUN = 1;
    localparam int EV_FIN = 2;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic [AW-1:0] last_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic [15:0]   instruction;
    logic          run;
    logic          done;
    logic [AW-1:0] pc;
    logic          busy;
    logic          finished;
    logic          timeout_err;
    logic [15:0]   instr_count;

    int          checks = 0;
    int          errors = 0;
    ev_t         ev_q[$];
    logic [15:0] mem[N];
    int          lat_tab[N];
    logic [15:0] model_instr;

    bitty_fetch_sequencer #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .last_addr   (last_addr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input logic [15:0] a, input logic [15:0] b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        ev_q.push_back(e);
    endfunction

    // Synchronous-read memory: data appears the cycle after mem_rd, garbage otherwise.
    initial begin
        logic          rd_pend;
        logic [AW-1:0] rd_addr;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            rd_pend = mem_rd;
            rd_addr = mem_addr;
            @(posedge clk);
            #1;
            mem_rdata = rd_pend ? mem[rd_addr] : 16'($urandom);
        end
    end

    // Core model: done lat_tab[pc] cycles after run (0 = never), stray dones otherwise.
    initial begin
        bit pend;
        bit hang;
        int cd;
        pend = 0;
        hang = 0;
        cd   = 0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !busy) begin
                pend = 0;
                hang = 0;
                done = !reset && ($urandom_range(0, 3) == 0);
            end else if (pend) begin
                cd--;
                done = (cd == 0);
                if (cd == 0) pend = 0;
            end else if (hang) begin
                done = 1'b0;
            end else begin
                done = ($urandom_range(0, 3) == 0);
                if (run) begin
                    if (lat_tab[pc] == 0) begin
                        hang = 1;
                    end else begin
                        pend = 1;
                        cd   = lat_tab[pc];
                    end
                end
            end
        end
    end

    task automatic check_ev(input int kind, input logic [15:0] a, input logic [15:0] b);
        ev_t e;
        if (ev_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d a=%0h expected no event", kind, a);
        end else begin
            e = ev_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    EV_RD:   chk("mem_addr", a, e.a);
                    EV_RUN: begin
                        chk("run_instruction", a, e.a);
                        chk("run_pc", b, e.b);
                    end
                    default: chk("finish_count", a, e.a);
                endcase
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_rd)   check_ev(EV_RD, 16'(mem_addr), 16'h0);
                if (run)      check_ev(EV_RUN, instruction, 16'(pc));
                if (finished) check_ev(EV_FIN, instr_count, 16'h0);
            end
        end
    end

    // mode: 0 complete, 1 stop in WAIT_MEM of instr a, 2 core hangs on instr a, 3 reset in EXEC of instr a
    task automatic run_prog(input int L, input int mode, input int a, input int lat_fix, input bit rand_mem);
        int          nrun, nf, cyc, run_cyc, exp_pc, exp_cnt;
        bit          stop_next, rst_next, terr_seen;
        logic [15:0] exp_instr;

        if (rand_mem) for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < N; i++)
            lat_tab[i] = (lat_fix > 0) ? lat_fix :
                         (($urandom_range(0, 5) == 0) ? TO - 1 : int'($urandom_range(1, 4)));
        if (mode == 0 && L >= 3 && lat_fix == 0) lat_tab[1] = TO - 1;
        if (mode == 2) lat_tab[a] = 0;

        nrun = (mode == 0) ? L + 1 : (mode == 1) ? a : a + 1;
        for (int k = 0; k < nrun; k++) begin
            push_ev(EV_RD, 16'(k), 16'h0);
            push_ev(EV_RUN, mem[k], 16'(k));
        end
        if (mode == 1) push_ev(EV_RD, 16'(a), 16'h0);
        if (mode == 0) push_ev(EV_FIN, 16'(L + 1), 16'h0);
        exp_pc    = (mode == 0) ? L : (mode == 3) ? 0 : a;
        exp_cnt   = (mode == 0) ? L + 1 : (mode == 3) ? 0 : a;
        case (mode)
            0:       exp_instr = mem[L];
            1:       exp_instr = (a > 0) ? mem[a - 1] : model_instr;
            2:       exp_instr = mem[a];
            default: exp_instr = 16'h0;
        endcase
        model_instr = exp_instr;

        @(negedge clk);
        last_addr = AW'(L);
        start     = 1'b1;
        stop      = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clears_terr", timeout_err, 0);
        chk("start_count", instr_count, 0);
        chk("start_pc", pc, 0);

        nf = 0; cyc = 0; run_cyc = 0;
        stop_next = 0; rst_next = 0; terr_seen = 0;
        forever begin
            if (rst_next) begin
                rst_next = 0;
                start    = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_run", run, 0);
                chk("rst_pc", pc, 0);
                chk("rst_count", instr_count, 0);
                chk("rst_finished", finished, 0);
                @(negedge clk);
                #2 reset = 1'b0;
            end
            stop      = stop_next;
            stop_next = 0;
            if (mem_rd) begin
                if (mode == 1 && nf == a) stop_next = 1;
                nf++;
            end
            if (run) begin
                run_cyc = cyc;
                if (mode == 3 && int'(pc) == a) rst_next = 1;
            end
            if (mode == 2 && timeout_err && !terr_seen) begin
                terr_seen = 1;
                chk("timeout_latency", cyc - run_cyc, TO);
            end
            if (!busy) break;
            if (cyc > 2000) begin
                chk("prog_cycle_budget", cyc, 0);
                break;
            end
            start     = ($urandom_range(0, 3) == 0);
            last_addr = AW'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;

        if (mode == 2) chk("timeout_seen", terr_seen, 1);
        chk("end_busy", busy, 0);
        chk("end_pc", pc, exp_pc);
        chk("end_count", instr_count, exp_cnt);
        chk("end_terr", timeout_err, (mode == 2) ? 1 : 0);
        chk("end_instruction", instruction, exp_instr);
        chk("events_left", ev_q.size(), 0);
        ev_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        last_addr   = '0;
        model_instr = 16'h0;
        for (int i = 0; i < N; i++) begin
            mem[i]     = 16'($urandom);
            lat_tab[i] = 1;
        end
        @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_pc", pc, 0);
        chk("reset_run", run, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_instruction", instruction, 0);
        chk("reset_finished", finished, 0);
        chk("reset_terr", timeout_err, 0);
        chk("reset_count", instr_count, 0);
        @(negedge clk);
        #2 reset = 1'b0;

        mem[0] = 16'h0011;
        mem[1] = 16'h2233;
        mem[2] = 16'h4455;
        run_prog(2, 0, 0, 2, 0);
        run_prog(0, 0, 0, 0, 1);
        run_prog(5, 2, 3, 0, 1);
        run_prog(9, 1, 5, 0, 1);
        run_prog(4, 3, 2, 0, 1);
        run_prog(N - 1, 0, 0, 0, 1);

        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        last_addr = AW'(3);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("startstop_still_idle", busy, 0);

        for (int r = 0; r < 12; r++) begin
            int m, l, ab;
            m  = $urandom_range(0, 3);
            l  = $urandom_range(0, N - 1);
            ab = $urandom_range(0, l);
            run_prog(l, m, ab, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
